// File: rtl/plugboard_pkg.sv
// Shared definitions for the plugboard slice.
//   state_t      handshake FSM states
//   LETTER_BASE  ASCII code of 'A'
//   NUM_LETTERS  letters in the alphabet
//   is_upper()   1 when an 8-bit char lies in 'A'..'Z'
package plugboard_pkg;

  localparam int LETTER_BASE = 65;
  localparam int NUM_LETTERS = 26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'(LETTER_BASE)) && (c <= 8'(LETTER_BASE + NUM_LETTERS - 1));
  endfunction

endpackage

// File: rtl/plugboard_map.sv
// plug_map: 26-entry swap table for the plugboard.
//   Each entry holds the partner index of its letter; unplugged letters point
//   at themselves. Pair writes are validated here and the sticky error and
//   installed-pair count live alongside the table. The lookup port is purely
//   combinational so the caller can register the result.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cfg_en             config allowed this cycle (owner is idle)
//   cfg_clear          restore identity, zero pair_cnt and cfg_err
//   cfg_we, cfg_a/b    install pair cfg_a <-> cfg_b
//   cfg_err            sticky rejected-write flag
//   pair_cnt           pairs currently installed
//   lk_char/lk_result  combinational char lookup
// Build option: PLUGBOARD_CASEFOLD_EN folds 'a'..'z' to 'A'..'Z' on both the
//   lookup path and the config letters.
module plug_map
  import plugboard_pkg::*;
#(
  parameter int MAX_PAIRS = 10,
  parameter int CHAR_W    = 8,
  parameter int BASE      = 65
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_en,
  input  logic              cfg_clear,
  input  logic              cfg_we,
  input  logic [CHAR_W-1:0] cfg_a,
  input  logic [CHAR_W-1:0] cfg_b,
  output logic              cfg_err,
  output logic [3:0]        pair_cnt,
  input  logic [CHAR_W-1:0] lk_char,
  output logic [CHAR_W-1:0] lk_result
);

  localparam int IDX_W = 5;
  localparam logic [CHAR_W-1:0] BASE_C = CHAR_W'(BASE);
  localparam logic [CHAR_W-1:0] LAST_C = CHAR_W'(BASE + NUM_LETTERS - 1);
`ifdef PLUGBOARD_CASEFOLD_EN
  localparam logic [CHAR_W-1:0] LOW_FIRST = CHAR_W'(BASE + 32);
  localparam logic [CHAR_W-1:0] LOW_LAST  = CHAR_W'(BASE + 32 + NUM_LETTERS - 1);
  localparam logic [CHAR_W-1:0] CASE_OFS  = CHAR_W'(32);
`endif

  logic [IDX_W-1:0] map_q [NUM_LETTERS];

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
`ifdef PLUGBOARD_CASEFOLD_EN
    if (c >= LOW_FIRST && c <= LOW_LAST) return c - CASE_OFS;
`endif
    return c;
  endfunction

  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return (c >= BASE_C) && (c <= LAST_C);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [CHAR_W-1:0] c);
    return IDX_W'(c - BASE_C);
  endfunction

  logic [CHAR_W-1:0] a_f, b_f, lk_f;
  logic [IDX_W-1:0]  a_idx, b_idx, lk_idx;
  logic              a_ok, b_ok, pair_ok;

  assign a_f    = fold(cfg_a);
  assign b_f    = fold(cfg_b);
  assign lk_f   = fold(lk_char);
  assign a_idx  = to_idx(a_f);
  assign b_idx  = to_idx(b_f);
  assign lk_idx = to_idx(lk_f);

  // Index reads are only meaningful once the letter range check has passed.
  assign a_ok = is_letter(a_f) && (map_q[a_idx] == a_idx);
  assign b_ok = is_letter(b_f) && (map_q[b_idx] == b_idx);
  assign pair_ok = a_ok && b_ok && (a_idx != b_idx) &&
                   (pair_cnt != 4'(MAX_PAIRS));

  assign lk_result = is_letter(lk_f) ? (CHAR_W'(map_q[lk_idx]) + BASE_C) : lk_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= IDX_W'(i);
      pair_cnt <= '0;
      cfg_err  <= 1'b0;
    end else if (cfg_en) begin
      if (cfg_clear) begin
        for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= IDX_W'(i);
        pair_cnt <= '0;
        cfg_err  <= 1'b0;
      end else if (cfg_we) begin
        if (pair_ok) begin
          map_q[a_idx] <= b_idx;
          map_q[b_idx] <= a_idx;
          pair_cnt     <= pair_cnt + 4'd1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/plugboard.sv
// plugboard: Enigma Steckerbrett stage in front of a rotor.
//   Accepts one char over in_valid/in_ready, swaps it through plug_map, pulses
//   out_valid for one cycle with the result on out_char, then waits for the
//   rotor's ds_done before taking the next char.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cfg_clear, cfg_we,
//   cfg_a, cfg_b           pair table configuration (honoured only when idle)
//   cfg_err, pair_cnt      config status
//   in_valid/in_ready/
//   in_char                input handshake
//   out_valid, out_char    1-cycle issue pulse and held result
//   ds_done                rotor completion
//   busy                   char in flight
// Build option: PLUGBOARD_CASEFOLD_EN (see plug_map).
//
// state  | meaning
// IDLE   | ready for a char or a config op
// LOOKUP | captured char goes through the table into out_char
// ISSUE  | out_valid high for this one cycle
// WAIT   | holding until ds_done
module plugboard
  import plugboard_pkg::*;
#(
  parameter int MAX_PAIRS = 10,
  parameter int CHAR_W    = 8,
  parameter int BASE      = LETTER_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_clear,
  input  logic              cfg_we,
  input  logic [CHAR_W-1:0] cfg_a,
  input  logic [CHAR_W-1:0] cfg_b,
  output logic              cfg_err,
  output logic [3:0]        pair_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  output logic              out_valid,
  output logic [CHAR_W-1:0] out_char,
  input  logic              ds_done,
  output logic              busy
);

  state_t            state;
  logic [CHAR_W-1:0] char_q;
  logic [CHAR_W-1:0] lk_result;
  logic              idle;

  assign idle     = (state == ST_IDLE);
  // A config op owns the idle cycle, so the table never changes under a char.
  assign in_ready = idle && !cfg_we && !cfg_clear;
  assign busy     = !idle;

  plug_map #(
    .MAX_PAIRS (MAX_PAIRS),
    .CHAR_W    (CHAR_W),
    .BASE      (BASE)
  ) u_map (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (idle),
    .cfg_clear (cfg_clear),
    .cfg_we    (cfg_we),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .cfg_err   (cfg_err),
    .pair_cnt  (pair_cnt),
    .lk_char   (char_q),
    .lk_result (lk_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      char_q    <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            char_q <= in_char;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          out_char  <= lk_result;
          out_valid <= 1'b1;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ds_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plugboard.sv
module tb_plugboard;

  localparam int MAXP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_clear = 1'b0, cfg_we = 1'b0;
  logic [7:0] cfg_a = 8'd0, cfg_b = 8'd0;
  logic       cfg_err;
  logic [3:0] pair_cnt;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'd0;
  logic       out_valid;
  logic [7:0] out_char;
  logic       ds_done = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plugboard dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_clear (cfg_clear),
    .cfg_we    (cfg_we),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .cfg_err   (cfg_err),
    .pair_cnt  (pair_cnt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_char  (out_char),
    .ds_done   (ds_done),
    .busy      (busy)
  );

  // ---------------- reference model: partner table in plain ints ----------------
  int  pm [26];
  int  m_cnt;
  bit  m_err;

  function automatic int fold(input int c);
`ifdef PLUGBOARD_CASEFOLD_EN
    if (c >= 97 && c <= 122) return c - 32;
`endif
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 26; i++) pm[i] = i;
    m_cnt = 0;
    m_err = 0;
  endfunction

  function automatic void m_write(input int a_raw, input int b_raw);
    int a, b;
    bit ok;
    a = fold(a_raw);
    b = fold(b_raw);
    ok = (a >= 65 && a <= 90) && (b >= 65 && b <= 90) && (a != b);
    if (ok) ok = (pm[a-65] == a-65) && (pm[b-65] == b-65) && (m_cnt < MAXP);
    if (ok) begin
      pm[a-65] = b - 65;
      pm[b-65] = a - 65;
      m_cnt++;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic int m_look(input int c);
    int f;
    f = fold(c);
    if (f >= 65 && f <= 90) return pm[f-65] + 65;
    return c;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("cfg_err", cfg_err, m_err);
    chk("pair_cnt", pair_cnt, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic cfg_write(input int a, input int b);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_a  = 8'(a);
    cfg_b  = 8'(b);
    #1 chk("ready_during_we", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    m_write(a, b);
    chk_status();
  endtask

  task automatic cfg_clr();
    @(negedge clk);
    cfg_clear = 1'b1;
    #1 chk("ready_during_clear", in_ready, 0);
    @(negedge clk);
    cfg_clear = 1'b0;
    m_clear();
    chk_status();
  endtask

  // Entered at the negedge where in_valid is up and in_ready was seen high;
  // the handshake completes at the following posedge (cycle T).
  task automatic finish_char(input int exp, input int dly, input bit early, input bit noise);
    @(negedge clk);                       // T+1 LOOKUP
    in_valid = 1'b0;
    chk("lookup_no_valid", out_valid, 0);
    chk("lookup_busy", busy, 1);
    if (early) ds_done = 1'b1;
    @(negedge clk);                       // T+2 ISSUE
    chk("issue_valid", out_valid, 1);
    chk("issue_char", out_char, exp);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);                     // WAIT cycles
      ds_done = 1'b0;
      chk("wait_no_valid", out_valid, 0);
      chk("wait_hold_char", out_char, exp);
      chk("wait_busy", busy, 1);
      if (noise && k == 0) begin
        cfg_clear = 1'b1;
        cfg_we    = 1'b1;
        cfg_a     = 8'd75;
        cfg_b     = 8'd76;
      end else begin
        cfg_clear = 1'b0;
        cfg_we    = 1'b0;
      end
      #1 chk("wait_not_ready", in_ready, 0);
      if (k == dly - 1) ds_done = 1'b1;
    end
    @(negedge clk);
    ds_done   = 1'b0;
    cfg_clear = 1'b0;
    cfg_we    = 1'b0;
    #1;
    chk("done_idle", busy, 0);
    chk("done_ready", in_ready, 1);
    chk("done_hold_char", out_char, exp);
    if (noise) chk_status();
  endtask

  task automatic send(input int c, input int exp, input int dly, input bit early, input bit noise);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'(c);
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      finish_char(exp, dly, early, noise);
    end
  endtask

  function automatic int rand_char();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(65, 90);
    if (r < 8) return $urandom_range(97, 122);
    case ($urandom_range(0, 4))
      0: return 64;
      1: return 91;
      2: return 96;
      3: return 123;
      default: return $urandom_range(48, 57);
    endcase
  endfunction

  typedef struct {
    int in_c;
    int exp_c;
    int dly;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{65, 90, 1};   // A -> Z
    tbl[1] = '{89, 66, 2};   // Y -> B
    tbl[2] = '{77, 77, 3};   // M unplugged
    tbl[3] = '{90, 65, 1};   // Z -> A
    tbl[4] = '{64, 64, 2};   // '@' just below A
    tbl[5] = '{91, 91, 1};   // '[' just above Z

    // 1: reset values, single char, ds_done 3 cycles after out_valid
    m_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_ready", in_ready, 1);
    chk_status();
    send(81, 81, 3, 0, 0);
    // ds_done during LOOKUP/ISSUE is ignored; WAIT still needs its own
    send(82, 82, 2, 1, 0);

    // 2: two pairs, table of chars
    cfg_write(65, 90);
    cfg_write(66, 89);
    foreach (tbl[i]) send(tbl[i].in_c, tbl[i].exp_c, tbl[i].dly, 0, 0);
    chk("pairs_two", pair_cnt, 2);
    chk("err_zero", cfg_err, 0);
    // config pulses while in WAIT are ignored
    send(66, 89, 2, 0, 1);

    // 3: rejected writes
    cfg_clr();
    cfg_write(65, 90);
    cfg_write(65, 67);
    cfg_write(81, 81);
    cfg_write(49, 66);
    chk("rej_err", cfg_err, 1);
    chk("rej_cnt", pair_cnt, 1);
    send(67, 67, 1, 0, 0);
    send(65, 90, 1, 0, 0);
    cfg_clr();
    chk("clr_err", cfg_err, 0);
    send(65, 65, 1, 0, 0);

    // 4: full table, then 11th rejected
    for (int i = 0; i < 10; i++) cfg_write(65 + 2*i, 66 + 2*i);
    chk("full_cnt", pair_cnt, 10);
    cfg_write(85, 86);
    chk("full_rej_cnt", pair_cnt, 10);
    chk("full_rej_err", cfg_err, 1);
    send(65, 66, 1, 0, 0);
    send(84, 83, 2, 0, 0);
    send(85, 85, 1, 0, 0);
    // clear wins over a same-cycle write
    @(negedge clk);
    cfg_clear = 1'b1;
    cfg_we    = 1'b1;
    cfg_a     = 8'd85;
    cfg_b     = 8'd86;
    @(negedge clk);
    cfg_clear = 1'b0;
    cfg_we    = 1'b0;
    m_clear();
    chk("clr_prio_cnt", pair_cnt, 0);
    chk("clr_prio_err", cfg_err, 0);
    // write and char offered together: write first, char next cycle
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_a    = 8'd87;
    cfg_b    = 8'd88;
    in_valid = 1'b1;
    in_char  = 8'd87;
    #1 chk("we_blocks_ready", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    m_write(87, 88);
    #1 chk("ready_after_we", in_ready, 1);
    chk("we_applied_cnt", pair_cnt, 1);
    finish_char(88, 1, 0, 0);

    // 5: reset in WAIT, and reset in LOOKUP
    cfg_write(65, 90);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'd65;
    @(negedge clk);
    in_valid = 1'b0;                // LOOKUP
    @(negedge clk);                 // ISSUE
    @(negedge clk);                 // WAIT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_valid", out_valid, 0);
    chk("rst_wait_char", out_char, 0);
    chk("rst_wait_cnt", pair_cnt, 0);
    ds_done = 1'b1;
    @(negedge clk);
    ds_done = 1'b0;
    chk("late_done_idle", busy, 0);
    chk("late_done_valid", out_valid, 0);
    send(65, 65, 1, 0, 0);

    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;                // LOOKUP
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_lookup_valid", out_valid, 0);
    chk("rst_lookup_busy", busy, 0);
    @(negedge clk);
    chk("rst_lookup_no_issue", out_valid, 0);

    cfg_write(65, 90);
`ifdef PLUGBOARD_CASEFOLD_EN
    send(97, 90, 1, 0, 0);
    cfg_write(98, 99);
    chk("fold_cfg_cnt", pair_cnt, 2);
`else
    send(97, 97, 1, 0, 0);
    cfg_write(98, 99);
    chk("nofold_cfg_err", cfg_err, 1);
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 0) begin
        cfg_clr();
      end else if (op < 7) begin
        cfg_write(rand_char(), rand_char());
      end else begin
        int c;
        c = rand_char();
        send(c, m_look(c), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
      end
    end
    chk_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
